// File: rtl/thermo_ramp_ctrl_pkg.sv
// rtl/thermo_ramp_ctrl_pkg.sv - shared constants (thermo_defs): state encodings and prescaler width helper
package thermo_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  // Prescaler width: max(1, clog2(div)); the prescaler only ever holds 0..div-1.
  function automatic int presc_width(input int div);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < div) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/thermo_ramp_ctrl_if.sv
// rtl/thermo_ramp_ctrl_if.sv - target request valid/ready handshake bundle
interface thermo_ramp_ctrl_if #(
  parameter int K = 3
);

  logic         tgt_valid;
  logic [K-1:0] tgt_level;
  logic         tgt_ready;

  // The control source drives the request; the ramp controller answers with ready.
  modport master (output tgt_valid, output tgt_level, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_level, output tgt_ready);

endinterface

// File: rtl/thermo_ramp_ctrl_encoder.sv
// rtl/thermo_ramp_ctrl_encoder.sv - thermometer_encoder: binary level to thermometer code
module thermometer_encoder #(
  parameter int K = 3,
  parameter int W = 7
) (
  input  logic [K-1:0] level,
  output logic [W-1:0] q
);

  // Bit i is set exactly when i is below the level, so the code fills from bit 0 upward.
  always_comb begin
    q = '0;
    for (int i = 0; i < W; i++) begin
      q[i] = (i < int'(level));
    end
  end

endmodule

// File: rtl/thermo_ramp_ctrl.sv
// rtl/thermo_ramp_ctrl.sv - ramp controller stepping level toward a target; option macro THERMO_RAMP_RETARGET_EN
module thermo_ramp_ctrl
  import thermo_ramp_ctrl_pkg::*;
#(
  parameter int K   = 3,
  parameter int W   = 7,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  thermo_ramp_ctrl_if.slave   tgt,
  output logic [K-1:0]        level,
  output logic [W-1:0]        q,
  output logic                busy,
  output logic                done
);

  localparam int            PW   = presc_width(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  state_t         state, state_n;
  logic [K-1:0]   target, target_n;
  logic [K-1:0]   level_n;
  logic [PW-1:0]  presc, presc_n;
  logic           done_n;
  logic           accept;

  // Ready policy: with retargeting a new request may land mid-ramp, otherwise only when idle.
`ifdef THERMO_RAMP_RETARGET_EN
  assign tgt.tgt_ready = 1'b1;
`else
  assign tgt.tgt_ready = (state == ST_IDLE);
`endif

  assign accept = tgt.tgt_valid & tgt.tgt_ready;
  assign busy   = (state != ST_IDLE);

  // Next-state: advance the ramp first, then let an accepted request override direction.
  always_comb begin
    state_n  = state;
    target_n = target;
    presc_n  = presc;
    level_n  = level;
    done_n   = 1'b0;

    if (state != ST_IDLE) begin
      if (presc == PMAX) begin
        presc_n = '0;
        level_n = (state == ST_UP) ? level + K'(1) : level - K'(1);
        if (level_n == target) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end

    if (accept) begin
      target_n = tgt.tgt_level;
`ifdef THERMO_RAMP_RETARGET_EN
      // A mid-ramp retarget keeps the running prescaler so step cadence is unchanged.
      if (state == ST_IDLE) presc_n = '0;
`else
      presc_n = '0;
`endif
      // Compare against the level after any step taken on this same edge.
      if (tgt.tgt_level > level_n) begin
        state_n = ST_UP;
        done_n  = 1'b0;
      end else if (tgt.tgt_level < level_n) begin
        state_n = ST_DOWN;
        done_n  = 1'b0;
      end else begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
    end
  end

  // State, target, prescaler, level and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      target <= '0;
      presc  <= '0;
      level  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      target <= target_n;
      presc  <= presc_n;
      level  <= level_n;
      done   <= done_n;
    end
  end

  thermometer_encoder #(
    .K (K),
    .W (W)
  ) u_enc (
    .level (level),
    .q     (q)
  );

endmodule
